// File: rtl/cu_pkg.sv
// Shared state encodings, opcode constants and small helpers for the multicycle
// RISC-V control-unit sequencer.
package cu_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEMADR    = 4'd2,
        S_MEMREAD   = 4'd3,
        S_MEMWB     = 4'd4,
        S_MEMWRITE  = 4'd5,
        S_EXEC_R    = 4'd6,
        S_ALUWB     = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP_LINK = 4'd9,
        S_JAL_PC    = 4'd10,
        S_AUIPC     = 4'd11,
        S_JALR_PC   = 4'd12,
        S_EXEC_I    = 4'd13,
        S_RSVD_14   = 4'd14,
        S_RSVD_15   = 4'd15
    } cu_state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IALU   = 7'b0010011;

    // Final step of an instruction: leaving one of these for FETCH retires it.
    function automatic logic retires_from(input cu_state_t s);
        logic r;
        r = 1'b0;
        case (s)
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_JAL_PC, S_JALR_PC: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cu_if.sv
// Control-unit sequencer interface: datapath inputs, control strobes, status
// pulses and performance counters, with master (sequencer) and slave views.
interface cu_if #(
    parameter int CNT_W = 32
) ();
    logic             run;
    logic [6:0]       op;
    logic             mem_ready;
    logic [3:0]       state;
    logic             mem_req;
    logic             mem_we;
    logic             ir_write;
    logic             pc_write;
    logic             pc_write_cond;
    logic             reg_write;
    logic             instr_done;
    logic             illegal_op;
    logic             mem_timeout;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    modport master (
        input  run, op, mem_ready,
        output state, mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write,
        output instr_done, illegal_op, mem_timeout, cycle_count, instr_count
    );

    modport slave (
        output run, op, mem_ready,
        input  state, mem_req, mem_we, ir_write, pc_write, pc_write_cond, reg_write,
        input  instr_done, illegal_op, mem_timeout, cycle_count, instr_count
    );
endinterface

// File: rtl/cu_mem_wait.sv
// Memory-wait counter: counts stalled cycles in a memory state and flags the
// cycle in which the wait budget runs out. TIMEOUT_CYCLES=0 disables expiry.
module cu_mem_wait #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic waiting,
    output logic expire
);

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout
            localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] count_reg;
            logic [CW-1:0] count_next;

            // clr wins so the count never runs past LAST: expiry also forces clr.
            always_comb begin
                count_next = count_reg;
                if (clr) begin
                    count_next = '0;
                end else if (waiting) begin
                    count_next = count_reg + CW'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_next;
                end
            end

            assign expire = waiting && (count_reg == LAST);
        end else begin : g_no_timeout
            assign expire = 1'b0;
        end
    endgenerate

endmodule

// File: rtl/cu_sequencer.sv
// Multicycle RISC-V control-unit sequencer: state register, next-state logic,
// Moore strobes, status pulses. Optional perf counters under CU_PERF_CNT_EN.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic clk,
    input  logic rst_n,
    cu_if.master bus
);

    cu_state_t state_reg;
    cu_state_t state_next;

    logic mem_req;
    logic mem_we;
    logic fetch_hit;
    logic jump_pc;
    logic pc_write_cond;
    logic reg_write;
    logic waiting;
    logic expire;
    logic wait_clr;
    logic done_next;
    logic illegal_next;

    logic instr_done_reg;
    logic illegal_op_reg;
    logic mem_timeout_reg;

    // Moore decode of the current state; only FETCH looks at run / mem_ready.
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        jump_pc       = 1'b0;
        pc_write_cond = 1'b0;
        reg_write     = 1'b0;
        fetch_hit     = 1'b0;
        case (state_reg)
            S_FETCH:                      mem_req = bus.run;
            S_MEMREAD:                    mem_req = 1'b1;
            S_MEMWRITE: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
            end
            S_BRANCH:                     pc_write_cond = 1'b1;
            S_MEMWB, S_ALUWB, S_JUMP_LINK: reg_write = 1'b1;
            S_JAL_PC, S_JALR_PC:          jump_pc = 1'b1;
            default: ;
        endcase
        fetch_hit = (state_reg == S_FETCH) && mem_req && bus.mem_ready;
    end

    assign waiting = mem_req && !bus.mem_ready;

    always_comb begin
        state_next   = state_reg;
        illegal_next = 1'b0;
        done_next    = 1'b0;
        case (state_reg)
            S_FETCH: begin
                if (fetch_hit) state_next = S_DECODE;
            end
            S_DECODE: begin
                case (bus.op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXEC_R;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL, OP_JALR:   state_next = S_JUMP_LINK;
                    OP_AUIPC:          state_next = S_AUIPC;
                    OP_IALU:           state_next = S_EXEC_I;
                    default: begin
                        state_next   = S_FETCH;
                        illegal_next = 1'b1;
                    end
                endcase
            end
            S_MEMADR:    state_next = (bus.op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD: begin
                if (bus.mem_ready) state_next = S_MEMWB;
            end
            S_MEMWRITE: begin
                if (bus.mem_ready) state_next = S_FETCH;
            end
            S_EXEC_R, S_EXEC_I, S_AUIPC: state_next = S_ALUWB;
            S_JUMP_LINK: state_next = (bus.op == OP_JAL) ? S_JAL_PC : S_JALR_PC;
            default:     state_next = S_FETCH;
        endcase

        // A stalled access that runs out of budget abandons the instruction.
        if (expire) begin
            state_next = S_FETCH;
        end
        done_next = (state_next == S_FETCH) && retires_from(state_reg) && !expire;
    end

    // A FETCH timeout does not change state, so expiry must clear the count too.
    assign wait_clr = (state_next != state_reg) || expire;

    cu_mem_wait #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_mem_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (wait_clr),
        .waiting (waiting),
        .expire  (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_FETCH;
            instr_done_reg  <= 1'b0;
            illegal_op_reg  <= 1'b0;
            mem_timeout_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            instr_done_reg  <= done_next;
            illegal_op_reg  <= illegal_next;
            mem_timeout_reg <= expire;
        end
    end

`ifdef CU_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_count_reg;
    logic [CNT_W-1:0] instr_count_reg;

    // instr_count steps on the same edge that raises instr_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_count_reg <= '0;
            instr_count_reg <= '0;
        end else begin
            cycle_count_reg <= cycle_count_reg + CNT_W'(1);
            if (done_next) begin
                instr_count_reg <= instr_count_reg + CNT_W'(1);
            end
        end
    end

    assign bus.cycle_count = cycle_count_reg;
    assign bus.instr_count = instr_count_reg;
`else
    assign bus.cycle_count = {CNT_W{1'b0}};
    assign bus.instr_count = {CNT_W{1'b0}};
`endif

    assign bus.state         = state_reg;
    assign bus.mem_req       = mem_req;
    assign bus.mem_we        = mem_we;
    assign bus.ir_write      = fetch_hit;
    assign bus.pc_write      = fetch_hit || jump_pc;
    assign bus.pc_write_cond = pc_write_cond;
    assign bus.reg_write     = reg_write;
    assign bus.instr_done    = instr_done_reg;
    assign bus.illegal_op    = illegal_op_reg;
    assign bus.mem_timeout   = mem_timeout_reg;

endmodule

// File: tb/tb_cu_sequencer.sv
// Self-checking bench for cu_sequencer: directed scenarios plus randomized
// traffic against a path-per-opcode reference model.
module tb_cu_sequencer;

    localparam int TO    = 4;
    localparam int CNT_W = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_BAD    = 7'b1111111;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cu_if #(.CNT_W(CNT_W)) bus ();

    cu_sequencer #(
        .TIMEOUT_CYCLES(TO),
        .CNT_W(CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model: an instruction is the list of states it visits after FETCH.
    int          m_path[$];
    int          m_idx = -1;
    bit          m_illegal = 1'b0;
    int          m_wait = 0;
    bit          m_done = 1'b0;
    bit          m_ill = 1'b0;
    bit          m_to = 1'b0;
    logic [CNT_W-1:0] m_cyc = '0;
    logic [CNT_W-1:0] m_ic = '0;

    bit          cur_run, cur_rdy, cur_rn;
    logic [6:0]  cur_op;
    logic [12:0] e_vec, o_vec;
    logic [63:0] e_cnt, o_cnt;

    function automatic int m_state();
        if (m_idx < 0) return 0;
        return m_path[m_idx];
    endfunction

    function automatic void build_path(input logic [6:0] op);
        m_illegal = 1'b0;
        case (op)
            OP_LOAD:   m_path = '{1, 2, 3, 4};
            OP_STORE:  m_path = '{1, 2, 5};
            OP_R:      m_path = '{1, 6, 7};
            OP_BRANCH: m_path = '{1, 8};
            OP_JAL:    m_path = '{1, 9, 10};
            OP_JALR:   m_path = '{1, 9, 12};
            OP_AUIPC:  m_path = '{1, 11, 7};
            OP_IALU:   m_path = '{1, 13, 7};
            default: begin
                m_path    = '{1};
                m_illegal = 1'b1;
            end
        endcase
    endfunction

    // Apply inputs at the falling edge, then capture observed and expected outputs.
    task automatic drive(input logic [6:0] op, input bit r, input bit rdy, input bit rn);
        int st;
        bit mreq, fh;
        @(negedge clk);
        bus.op = op;
        bus.run = r;
        bus.mem_ready = rdy;
        rst_n = rn;
        cur_op = op;
        cur_run = r;
        cur_rdy = rdy;
        cur_rn = rn;
        #1;
        st = m_state();
        mreq = (st == 0 && r) || st == 3 || st == 5;
        fh = (st == 0) && mreq && rdy;
        e_vec = {4'(st), mreq, st == 5, fh, fh || st == 10 || st == 12, st == 8,
                 st == 4 || st == 7 || st == 9, m_done, m_ill, m_to};
        o_vec = {bus.state, bus.mem_req, bus.mem_we, bus.ir_write, bus.pc_write,
                 bus.pc_write_cond, bus.reg_write, bus.instr_done, bus.illegal_op, bus.mem_timeout};
`ifdef CU_PERF_CNT_EN
        e_cnt = {m_cyc, m_ic};
`else
        e_cnt = '0;
`endif
        o_cnt = {bus.cycle_count, bus.instr_count};
    endtask

    // Advance the model by one clock using the inputs applied by drive().
    task automatic advance();
        int st;
        bit mreq;
        bit nd, ni, nt;
        nd = 1'b0; ni = 1'b0; nt = 1'b0;
        st = m_state();
        mreq = (st == 0 && cur_run) || st == 3 || st == 5;
        if (!cur_rn) begin
            m_idx = -1; m_wait = 0; m_cyc = '0; m_ic = '0;
        end else begin
            if (st == 0 && !cur_run) begin
                // idle in FETCH
            end else if (mreq && !cur_rdy) begin
                if (TO > 0 && m_wait == TO - 1) begin
                    nt = 1'b1; m_idx = -1; m_wait = 0;
                end else begin
                    m_wait++;
                end
            end else begin
                m_wait = 0;
                if (st == 0) begin
                    build_path(cur_op);
                    m_idx = 0;
                end else if (m_idx == m_path.size() - 1) begin
                    m_idx = -1;
                    if (m_illegal) ni = 1'b1; else nd = 1'b1;
                end else begin
                    m_idx++;
                end
            end
            m_cyc = m_cyc + 1'b1;
            if (nd) m_ic = m_ic + 1'b1;
        end
        m_done = nd; m_ill = ni; m_to = nt;
        @(posedge clk);
    endtask

    task automatic test_reset();
        drive(OP_R, 1'b0, 1'b0, 1'b0); advance();
        drive(OP_R, 1'b0, 1'b0, 1'b0); advance();
        drive(OP_R, 1'b0, 1'b0, 1'b1);
        if (o_vec !== e_vec) begin failures++; $display("FAIL reset outputs got=%h exp=%h", o_vec, e_vec); end
        if (o_cnt !== 64'd0) begin failures++; $display("FAIL reset counters got=%h exp=0", o_cnt); end
        if (bus.state !== 4'd0) begin failures++; $display("FAIL reset state got=%0d exp=0", bus.state); end
        checks += 3;
        advance();
        $display("reset: state and counters cleared");
    endtask

    task automatic test_r_type();
        int seq[5] = '{0, 1, 6, 7, 0};
        for (int k = 0; k < 5; k++) begin
            drive(OP_R, k < 4, 1'b1, 1'b1);
            if (o_vec !== e_vec) begin failures++; $display("FAIL r_type step%0d got=%h exp=%h", k, o_vec, e_vec); end
            if (o_cnt !== e_cnt) begin failures++; $display("FAIL r_type cnt step%0d got=%h exp=%h", k, o_cnt, e_cnt); end
            if (bus.state !== 4'(seq[k])) begin failures++; $display("FAIL r_type state step%0d got=%0d exp=%0d", k, bus.state, seq[k]); end
            if (bus.reg_write !== (seq[k] == 7)) begin failures++; $display("FAIL r_type reg_write step%0d got=%b", k, bus.reg_write); end
            if (bus.instr_done !== (k == 4)) begin failures++; $display("FAIL r_type instr_done step%0d got=%b", k, bus.instr_done); end
            checks += 5;
            advance();
        end
        $display("r_type: 0,1,6,7,0 retired");
    endtask

    task automatic test_load_wait();
        int seq[9] = '{0, 1, 2, 3, 3, 3, 3, 4, 0};
        bit rdy[9] = '{1, 1, 1, 0, 0, 0, 1, 1, 1};
        int dones = 0;
        for (int k = 0; k < 9; k++) begin
            drive(OP_LOAD, k == 0, rdy[k], 1'b1);
            if (o_vec !== e_vec) begin failures++; $display("FAIL load step%0d got=%h exp=%h", k, o_vec, e_vec); end
            if (o_cnt !== e_cnt) begin failures++; $display("FAIL load cnt step%0d got=%h exp=%h", k, o_cnt, e_cnt); end
            if (bus.state !== 4'(seq[k])) begin failures++; $display("FAIL load state step%0d got=%0d exp=%0d", k, bus.state, seq[k]); end
            if (bus.mem_timeout !== 1'b0) begin failures++; $display("FAIL load mem_timeout step%0d got=1 exp=0", k); end
            checks += 4;
            if (bus.instr_done === 1'b1) dones++;
            advance();
        end
        if (dones != 1) begin failures++; $display("FAIL load instr_done_count got=%0d exp=1", dones); end
        checks++;
        $display("load: 3-cycle stall in MEMREAD, ready on last wait cycle");
    endtask

    task automatic test_store();
        int seq[5] = '{0, 1, 2, 5, 0};
        for (int k = 0; k < 5; k++) begin
            drive(OP_STORE, k == 0, 1'b1, 1'b1);
            if (o_vec !== e_vec) begin failures++; $display("FAIL store step%0d got=%h exp=%h", k, o_vec, e_vec); end
            if (bus.state !== 4'(seq[k])) begin failures++; $display("FAIL store state step%0d got=%0d exp=%0d", k, bus.state, seq[k]); end
            if (bus.mem_we !== (seq[k] == 5)) begin failures++; $display("FAIL store mem_we step%0d got=%b", k, bus.mem_we); end
            if (bus.reg_write !== 1'b0) begin failures++; $display("FAIL store reg_write step%0d got=1 exp=0", k); end
            checks += 4;
            advance();
        end
        $display("store: 0,1,2,5,0 retired");
    endtask

    task automatic test_jumps();
        int seq[5];
        logic [6:0] ops[2] = '{OP_JALR, OP_JAL};
        for (int j = 0; j < 2; j++) begin
            seq = '{0, 1, 9, (j == 0) ? 12 : 10, 0};
            for (int k = 0; k < 5; k++) begin
                drive(ops[j], k == 0, 1'b1, 1'b1);
                if (o_vec !== e_vec) begin failures++; $display("FAIL jump%0d step%0d got=%h exp=%h", j, k, o_vec, e_vec); end
                if (bus.state !== 4'(seq[k])) begin failures++; $display("FAIL jump%0d state step%0d got=%0d exp=%0d", j, k, bus.state, seq[k]); end
                if (bus.pc_write !== (k == 0 || seq[k] == 10 || seq[k] == 12)) begin
                    failures++; $display("FAIL jump%0d pc_write step%0d got=%b", j, k, bus.pc_write);
                end
                checks += 3;
                advance();
            end
        end
        $display("jumps: jalr via 12, jal via 10");
    endtask

    task automatic test_illegal();
        for (int k = 0; k < 4; k++) begin
            drive(OP_BAD, k == 0, 1'b1, 1'b1);
            if (o_vec !== e_vec) begin failures++; $display("FAIL illegal step%0d got=%h exp=%h", k, o_vec, e_vec); end
            if (o_cnt !== e_cnt) begin failures++; $display("FAIL illegal cnt step%0d got=%h exp=%h", k, o_cnt, e_cnt); end
            if (bus.illegal_op !== (k == 2)) begin failures++; $display("FAIL illegal pulse step%0d got=%b", k, bus.illegal_op); end
            if (bus.instr_done !== 1'b0) begin failures++; $display("FAIL illegal instr_done step%0d got=1 exp=0", k); end
            checks += 4;
            advance();
        end
        $display("illegal: opcode 1111111 aborted to FETCH");
    endtask

    task automatic test_timeout();
        int seq[9] = '{0, 1, 2, 5, 5, 5, 5, 0, 0};
        for (int k = 0; k < 6; k++) begin
            drive(OP_R, k < 4, 1'b0, 1'b1);
            if (o_vec !== e_vec) begin failures++; $display("FAIL fetch_to step%0d got=%h exp=%h", k, o_vec, e_vec); end
            if (bus.state !== 4'd0) begin failures++; $display("FAIL fetch_to state step%0d got=%0d exp=0", k, bus.state); end
            if (bus.mem_timeout !== (k == 4)) begin failures++; $display("FAIL fetch_to pulse step%0d got=%b", k, bus.mem_timeout); end
            checks += 3;
            advance();
        end
        for (int k = 0; k < 9; k++) begin
            drive(OP_STORE, k == 0, k < 3, 1'b1);
            if (o_vec !== e_vec) begin failures++; $display("FAIL store_to step%0d got=%h exp=%h", k, o_vec, e_vec); end
            if (bus.state !== 4'(seq[k])) begin failures++; $display("FAIL store_to state step%0d got=%0d exp=%0d", k, bus.state, seq[k]); end
            if (bus.mem_timeout !== (k == 7)) begin failures++; $display("FAIL store_to pulse step%0d got=%b", k, bus.mem_timeout); end
            if (bus.instr_done !== 1'b0) begin failures++; $display("FAIL store_to instr_done step%0d got=1 exp=0", k); end
            checks += 4;
            advance();
        end
        $display("timeout: FETCH and MEMWRITE stalls expired after %0d cycles", TO);
    endtask

    task automatic test_mid_reset();
        bit rn[4] = '{1, 1, 0, 1};
        for (int k = 0; k < 4; k++) begin
            drive(OP_R, k == 0, 1'b1, rn[k]);
            if (o_vec !== e_vec) begin failures++; $display("FAIL mid_reset step%0d got=%h exp=%h", k, o_vec, e_vec); end
            if (o_cnt !== e_cnt) begin failures++; $display("FAIL mid_reset cnt step%0d got=%h exp=%h", k, o_cnt, e_cnt); end
            checks += 2;
            advance();
        end
        drive(OP_R, 1'b0, 1'b1, 1'b1);
        if ({bus.state, bus.instr_done, bus.illegal_op, bus.mem_timeout} !== 7'd0) begin
            failures++; $display("FAIL mid_reset quiet got state=%0d pulses=%b%b%b", bus.state,
                                 bus.instr_done, bus.illegal_op, bus.mem_timeout);
        end
        checks++;
        advance();
        $display("mid_reset: EXEC_R aborted without pulses");
    endtask

    task automatic test_random();
        logic [6:0] legal[8] = '{OP_LOAD, OP_STORE, OP_R, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_IALU};
        logic [6:0] op = OP_R;
        int retired = 0;
        for (int k = 0; k < 400; k++) begin
            if (m_state() == 0) begin
                op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : legal[$urandom_range(0, 7)];
            end
            drive(op, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 63) != 0);
            if (o_vec !== e_vec) begin failures++; $display("FAIL random cyc%0d op=%b got=%h exp=%h", k, op, o_vec, e_vec); end
            if (o_cnt !== e_cnt) begin failures++; $display("FAIL random cnt cyc%0d got=%h exp=%h", k, o_cnt, e_cnt); end
            checks += 2;
            if (bus.instr_done === 1'b1) retired++;
            advance();
        end
        $display("random: 400 cycles, %0d instructions retired", retired);
    endtask

    initial begin
        bus.run = 1'b0;
        bus.op = 7'd0;
        bus.mem_ready = 1'b0;
        test_reset();
        test_r_type();
        test_load_wait();
        test_store();
        test_jumps();
        test_illegal();
        test_timeout();
        test_mid_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
